// File: rtl/quarantine_ctrl.sv
// quarantine_ctrl: debounced start / four-phase completion handshake for the LED countdown
//   CLOCK      system clock, the only clock
//   RESETN     asynchronous active-low reset
//   btnC       raw push-button (asynchronous, bouncy)
//   resetQUAR  countdown-complete level from the slow animation domain
//   QUAR       requests and sustains a countdown
//   resetFLAG  completion acknowledge, held until resetQUAR drops
//   BUSY       high whenever the controller is not idle
//   ERR        sticky timeout flag, cleared by the next accepted press
module quarantine_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 32'd3_000_000_000
) (
    input  logic CLOCK,
    input  logic RESETN,
    input  logic btnC,
    input  logic resetQUAR,
    output logic QUAR,
    output logic resetFLAG,
    output logic BUSY,
    output logic ERR
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, ACK = 2'd2;
    logic [1:0]  b_sync, rq_sync, state;
    logic        b_s, rq_s, b_db, b_prev, press;
    logic [31:0] db_cnt, t_cnt;
    assign b_s   = b_sync[1];
    assign rq_s  = rq_sync[1];
    assign press = b_db & ~b_prev;
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            b_sync    <= '0;
            rq_sync   <= '0;
            b_db      <= 1'b0;
            b_prev    <= 1'b0;
            db_cnt    <= '0;
            t_cnt     <= '0;
            state     <= IDLE;
            QUAR      <= 1'b0;
            resetFLAG <= 1'b0;
            BUSY      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            b_sync  <= {b_sync[0], btnC};
            rq_sync <= {rq_sync[0], resetQUAR};
            b_prev  <= b_db;
            // The level is accepted on the edge that would make the count reach
            // DEBOUNCE_CYCLES, so press-to-QUAR is exactly DEBOUNCE_CYCLES + 3.
            if (b_s == b_db)
                db_cnt <= '0;
            else if (db_cnt == DEBOUNCE_CYCLES - 1) begin
                b_db   <= b_s;
                db_cnt <= '0;
            end else
                db_cnt <= db_cnt + 1;
            case (state)
                IDLE: begin
                    // A completion still asserted from an earlier run is acknowledged first.
                    if (rq_s) begin
                        state     <= ACK;
                        resetFLAG <= 1'b1;
                        BUSY      <= 1'b1;
                    end else if (press) begin
                        state <= RUN;
                        QUAR  <= 1'b1;
                        BUSY  <= 1'b1;
                        ERR   <= 1'b0;
                        t_cnt <= '0;
                    end
                end
                RUN: begin
                    if (rq_s) begin
                        state     <= ACK;
                        QUAR      <= 1'b0;
                        resetFLAG <= 1'b1;
                    end else if (t_cnt == TIMEOUT_CYCLES) begin
                        state <= IDLE;
                        QUAR  <= 1'b0;
                        BUSY  <= 1'b0;
                        ERR   <= 1'b1;
                    end else
                        t_cnt <= t_cnt + 1;
                end
                ACK: begin
                    if (!rq_s) begin
                        state     <= IDLE;
                        resetFLAG <= 1'b0;
                        BUSY      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
